// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a small circular buffer between fetch and decode.
// Fetch pushes (pc, instr) pairs; decode pops them in order. A flush discards
// every held entry on a branch redirect. The head entry is flagged illegal when
// its low two bits do not mark a 32-bit encoding.
// Optional feature: define IF_ID_BYPASS_EN to let an entry arriving at an empty
// queue appear at the output in the same cycle (and skip storage when consumed).
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);

  // Entry storage is never reset; only the pointers and occupancy are.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic head_vld;
  logic push;
  logic pop;
  logic store;

  // A 32-bit RISC-V encoding has both low bits set; anything else is rejected.
  function automatic logic is_illegal(input logic [XLEN-1:0] word);
    return word[1:0] != 2'b11;
  endfunction

  assign count    = cnt;
  assign head_vld = (cnt != '0);
  // in_ready depends only on occupancy and reset, never on out_ready.
  assign in_ready = (cnt < FULL_CNT) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = head_vld && out_ready;

`ifdef IF_ID_BYPASS_EN
  logic byp;
  assign byp   = !head_vld && in_valid && !flush && !rst;
  // A bypassed entry taken by decode in the same cycle never enters storage.
  assign store = push && !(byp && out_ready);
`else
  assign store = push;
`endif

  // Head presentation: stored entry, optional bypass, otherwise a NOP bubble.
  always_comb begin
    out_valid = head_vld;
    out_pc    = '0;
    out_instr = NOP;
    if (head_vld) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end
`ifdef IF_ID_BYPASS_EN
    else if (byp) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
    out_illegal = out_valid && is_illegal(out_instr);
  end

  // Pointer and occupancy control: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({store, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry write: data path only, discarded when a flush wins the cycle.
  always_ff @(posedge clk) begin
    if (store && !flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2, XLEN=32). Stimulus pushes the
// expected head entries into a scoreboard; a negedge monitor pops and compares
// whenever decode consumes an entry.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [1:0]  count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  if_id_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_illegal(out_illegal),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr, input logic ill);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.ill   = ill;
    exp_q.push_back(e);
  endtask

  // Run with current inputs until every expected entry has emerged (bounded).
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step();
      at_neg();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    step();
    at_neg();
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  // Output monitor: compare each consumed head entry against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %0h instr %0h, required no output", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("out_instr", 64'(out_instr), 64'(e.instr));
        chk("out_illegal", 64'(out_illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset held for two cycles
    step();
    at_neg();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    step();
    rst = 1'b0;
    at_neg();
    chk("rel_count", 64'(count), 64'd0);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_out_instr", 64'(out_instr), 64'h13);
    chk("rel_out_pc", 64'(out_pc), 64'd0);
    chk("rel_out_illegal", 64'(out_illegal), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // In-order pass with decode always ready
    step();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'd0; in_instr = 32'hffc4a303;
    expect_out(32'd0, 32'hffc4a303, 1'b0);
    step();
    in_pc = 32'd4; in_instr = 32'h0064a423;
    expect_out(32'd4, 32'h0064a423, 1'b0);
    step();
    in_valid = 1'b0;
    drain();

    // Backpressure until full, then a single pop
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'd0; in_instr = 32'h00000093;
    expect_out(32'd0, 32'h00000093, 1'b0);
    step();
    in_pc = 32'd4; in_instr = 32'h00100113;
    expect_out(32'd4, 32'h00100113, 1'b0);
    step();
    in_pc = 32'd8; in_instr = 32'h00200193;
    at_neg();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    step();
    in_valid = 1'b0;
    at_neg();
    chk("held_count", 64'(count), 64'd2);
    chk("held_in_ready", 64'(in_ready), 64'd0);
    chk("held_out_pc", 64'(out_pc), 64'd0);
    chk("held_out_valid", 64'(out_valid), 64'd1);
    step();
    out_ready = 1'b1;
    at_neg();
    step();
    out_ready = 1'b0;
    at_neg();
    chk("one_pop_count", 64'(count), 64'd1);
    chk("one_pop_in_ready", 64'(in_ready), 64'd1);
    chk("one_pop_out_pc", 64'(out_pc), 64'd4);
    step();
    out_ready = 1'b1;
    drain();

    // Wrap-around: ten back-to-back pushes with simultaneous pops
    for (int i = 0; i < 10; i++) begin
      step();
      in_valid = 1'b1;
      in_pc    = 32'(4 * i);
      in_instr = {8'(i), 24'h000093};
      expect_out(32'(4 * i), {8'(i), 24'h000093}, 1'b0);
      at_neg();
      chk("wrap_count_le1", 64'(count <= 2'd1), 64'd1);
    end
    step();
    in_valid = 1'b0;
    drain();

    // Flush with a same-cycle push; pc 12 must never emerge
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'd0; in_instr = 32'h00000093;
    step();
    in_pc = 32'd4;
    step();
    flush = 1'b1; in_pc = 32'd12; in_instr = 32'h00c00093;
    at_neg();
    chk("pre_flush_count", 64'(count), 64'd2);
    step();
    flush = 1'b0; in_valid = 1'b0;
    at_neg();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_instr", 64'(out_instr), 64'h13);
    step();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'd16; in_instr = 32'h01000093;
    expect_out(32'd16, 32'h01000093, 1'b0);
    step();
    in_valid = 1'b0;
    drain();

    // Illegal encoding, and bypass behaviour at an empty queue
    step();
    in_valid = 1'b1; in_pc = 32'd20; in_instr = 32'hfe420ae0;
    expect_out(32'd20, 32'hfe420ae0, 1'b1);
    at_neg();
`ifdef IF_ID_BYPASS_EN
    chk("byp_out_valid", 64'(out_valid), 64'd1);
    chk("byp_out_pc", 64'(out_pc), 64'd20);
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("nobyp_out_valid", 64'(out_valid), 64'd0);
`endif
    step();
    in_valid = 1'b0;
    at_neg();
`ifdef IF_ID_BYPASS_EN
    chk("byp_count_after", 64'(count), 64'd0);
`else
    chk("lat1_out_valid", 64'(out_valid), 64'd1);
    chk("lat1_count", 64'(count), 64'd1);
`endif
    drain();

    // Reset asserted mid-stream while full; the same-cycle push is lost
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h00000093;
    step();
    in_pc = 32'h104;
    step();
    rst = 1'b1; in_pc = 32'h108;
    at_neg();
    chk("pre_rst_count", 64'(count), 64'd2);
    chk("in_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    at_neg();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    step();
    at_neg();
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of stored fetch entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have parameter XLEN, default 32, width of the PC and instruction fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, the fetch stage presents an entry.
REQ-006 SHALL have port in_ready, output, 1, the queue can accept an entry this cycle.
REQ-007 SHALL have port in_pc, input, XLEN, PC of the fetched instruction.
REQ-008 SHALL have port in_instr, input, XLEN, fetched instruction word (little-endian assembled).
REQ-009 SHALL have port flush, input, 1, discard all held entries (branch redirect).
REQ-010 SHALL have port out_valid, output, 1, the head entry is presented to decode.
REQ-011 SHALL have port out_ready, input, 1, decode consumes the head entry.
REQ-012 SHALL have port out_pc, output, XLEN, PC of the head entry.
REQ-013 SHALL have port out_instr, output, XLEN, instruction of the head entry.
REQ-014 SHALL have port out_illegal, output, 1, asserted when out_instr[1:0] != 2'b11 (non-32-bit encoding).
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, number of held entries.

Function
REQ-016 SHALL treat a push as in_valid && in_ready at posedge, and a pop as out_valid && out_ready at posedge.
REQ-017 SHALL drive in_ready = (count < DEPTH) && !rst, independent of out_ready, so there is no combinational path from out_ready to in_ready.
REQ-018 SHALL implement a circular buffer with rd_ptr/wr_ptr wrapping modulo DEPTH; count updates +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
REQ-019 SHALL allow a simultaneous push and pop when 0 < count < DEPTH; when full, no push occurs (in_ready=0) but a pop is permitted.
REQ-020 SHALL drive out_valid = (count != 0); out_pc and out_instr come from the rd_ptr entry, with a push-to-out_valid latency of 1 cycle.
REQ-021 SHALL hold out_pc, out_instr, and out_illegal stable while out_valid && !out_ready.
REQ-022 SHALL drive out_pc = 0 and out_instr = 32'h00000013 (NOP) whenever out_valid=0; out_illegal is then 0.
REQ-023 SHALL, on flush at posedge, set count=0 and both pointers to 0; flush has priority over a same-cycle push and pop, and both are discarded.
REQ-024 SHALL accept pushes from the cycle after the flush; in_ready is unaffected by flush except through count.
REQ-025 SHALL leave a pop attempted while count=0 with no effect, and count shall never underflow or overflow.

Reset
REQ-026 SHALL, when rst=1 at posedge, set count=0, rd_ptr=0, and wr_ptr=0, giving out_valid=0, out_pc=0, out_instr=32'h00000013, out_illegal=0, and in_ready=0 while rst is high.
REQ-027 SHALL give rst priority over flush, push, and pop; storage contents need not be cleared.
REQ-028 SHALL, when rst is asserted mid-stream with count=DEPTH, produce count=0 next cycle, and data pushed in that cycle is lost.

Configuration
REQ-029 SHALL support macro IF_ID_BYPASS_EN; when defined and count=0 && in_valid && !flush, out_valid=1 combinationally with out_pc/out_instr = in_pc/in_instr.
REQ-030 SHALL, with IF_ID_BYPASS_EN defined, not store a bypassed entry consumed in the same cycle (out_ready=1), leaving count unchanged; if out_ready=0, the entry is pushed normally.
REQ-031 SHALL, without IF_ID_BYPASS_EN, give a minimum push-to-out_valid latency of exactly 1 cycle and include no in_* to out_* combinational path.

Verification
REQ-032 Bench SHALL cover reset: rst=1 for 2 cycles then 0 -> count=0, out_valid=0, out_instr=32'h00000013, and in_ready=1 after release.
REQ-033 Bench SHALL cover in-order pass: push (pc 0, 32'hffc4a303), (pc 4, 32'h0064a423) with out_ready=1 -> out shows pc 0 then pc 4 in order, both out_illegal=0, count back to 0.
REQ-034 Bench SHALL cover full/backpressure: out_ready=0 with 3 pushes (pc 0,4,8) at DEPTH=2 -> count=2, in_ready=0, pc 8 not accepted, out_pc=0 held; then out_ready=1 for 1 cycle -> count=1 and in_ready=1.
REQ-035 Bench SHALL cover wrap-around: 10 back-to-back pushes of pc 0..36 step 4 with out_ready=1 (simultaneous push/pop) -> all 10 PCs emerge in order, count<=1 throughout.
REQ-036 Bench SHALL cover flush: count=2 with flush=1 and in_valid=1 (pc 12) same cycle -> next cycle count=0, out_valid=0, and pc 12 never emerges.
REQ-037 Bench SHALL cover illegal encoding and bypass: push 32'hfe420ae0 -> out_illegal=1; with IF_ID_BYPASS_EN, empty queue, in_valid=1, out_ready=1 -> out_valid=1 the same cycle and count stays 0.
